// File: rtl/mem_io_bridge.sv
// mem_io_bridge: 32-bit word RAM plus a memory-mapped UART transmitter
// (4-entry byte FIFO, STATUS register, 8N1 serial framing).
// Optional feature macro: MEM_IO_BRIDGE_PARITY_EN adds an even-parity bit
// between the data bits and the stop bit (11-bit frame instead of 10).
module mem_io_bridge #(
  parameter int CLK_DIV   = 16,
  parameter int RAM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        txd
);

  localparam int          AW          = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [31:0] TXDATA_ADDR = 32'hFFFF_0000;
  localparam logic [31:0] STATUS_ADDR = 32'hFFFF_0004;
  localparam logic [31:0] RAM_BYTES   = 32'(4 * RAM_WORDS);
  localparam logic [15:0] BAUD_LAST   = 16'(CLK_DIV - 1);

`ifdef MEM_IO_BRIDGE_PARITY_EN
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4} tx_state_t;
`else
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4} tx_state_t;
`endif

  logic [31:0]   ram [RAM_WORDS];
  logic [7:0]    fifo [4];
  logic [1:0]    wptr, rptr;
  logic [2:0]    count;
  logic          overflow;

  tx_state_t     state;
  logic [15:0]   baud;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          par;

  logic          ram_sel, tx_wr, st_wr, fifo_full, fifo_empty;
  logic          push, drop, pop, tx_active, baud_done;
  logic [AW-1:0] ram_idx;

  // Address decode and FIFO/FSM handshake terms
  assign ram_sel    = (addr < RAM_BYTES);
  assign ram_idx    = addr[AW+1:2];
  assign tx_wr      = memwrite && (addr == TXDATA_ADDR);
  assign st_wr      = memwrite && (addr == STATUS_ADDR);
  assign fifo_full  = (count == 3'd4);
  assign fifo_empty = (count == 3'd0);
  // Fullness is judged before any same-edge pop, so a push while full is dropped
  assign push       = tx_wr && !fifo_full;
  assign drop       = tx_wr && fifo_full;
  assign tx_active  = (state != IDLE);
  assign baud_done  = (baud == BAUD_LAST);
  assign pop        = !fifo_empty && ((state == IDLE) || ((state == STOP) && baud_done));

  // RAM write port; contents are deliberately kept across reset
  always_ff @(posedge clk) begin
    if (memwrite && ram_sel) begin
      ram[ram_idx] <= writedata;
    end
  end

  // Combinational load path: RAM, STATUS, everything else reads as zero
  always_comb begin
    readdata = 32'h0000_0000;
    if (ram_sel) begin
      readdata = ram[ram_idx];
    end else if (addr == STATUS_ADDR) begin
      readdata = {28'h000_0000, overflow, tx_active, fifo_empty, fifo_full};
    end else begin
      readdata = 32'h0000_0000;
    end
  end

  // TX FIFO pointers, occupancy and sticky overflow (a drop wins over a clear)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo     <= '{default: 8'h00};
      wptr     <= 2'd0;
      rptr     <= 2'd0;
      count    <= 3'd0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        fifo[wptr] <= writedata[7:0];
        wptr       <= wptr + 2'd1;
      end
      if (pop) begin
        rptr <= rptr + 2'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end else if (st_wr) begin
        overflow <= 1'b0;
      end
    end
  end

  // Transmit FSM: start bit, 8 data bits LSB first, optional parity, stop bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      txd    <= 1'b1;
      baud   <= 16'd0;
      bitcnt <= 3'd0;
      shreg  <= 8'h00;
      par    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state <= START;
            txd   <= 1'b0;
            baud  <= 16'd0;
            shreg <= fifo[rptr];
            par   <= ^fifo[rptr];
          end
        end
        START: begin
          if (baud_done) begin
            baud   <= 16'd0;
            bitcnt <= 3'd0;
            state  <= DATA;
            txd    <= shreg[0];
          end else begin
            baud <= baud + 16'd1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud <= 16'd0;
            if (bitcnt == 3'd7) begin
`ifdef MEM_IO_BRIDGE_PARITY_EN
              state <= PARITY;
              txd   <= par;
`else
              state <= STOP;
              txd   <= 1'b1;
`endif
            end else begin
              bitcnt <= bitcnt + 3'd1;
              shreg  <= {1'b0, shreg[7:1]};
              txd    <= shreg[1];
            end
          end else begin
            baud <= baud + 16'd1;
          end
        end
`ifdef MEM_IO_BRIDGE_PARITY_EN
        PARITY: begin
          if (baud_done) begin
            baud  <= 16'd0;
            state <= STOP;
            txd   <= 1'b1;
          end else begin
            baud <= baud + 16'd1;
          end
        end
`endif
        STOP: begin
          if (baud_done) begin
            baud <= 16'd0;
            if (pop) begin
              state <= START;
              txd   <= 1'b0;
              shreg <= fifo[rptr];
              par   <= ^fifo[rptr];
            end else begin
              state <= IDLE;
              txd   <= 1'b1;
            end
          end else begin
            baud <= baud + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
          baud  <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io_bridge.sv
// tb_mem_io_bridge: directed self-checking bench for mem_io_bridge
// (CLK_DIV=16, RAM_WORDS=64). Honours MEM_IO_BRIDGE_PARITY_EN.
`timescale 1ns/1ps
module tb_mem_io_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic        txd;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] TXA = 32'hFFFF_0000;
  localparam logic [31:0] STA = 32'hFFFF_0004;
`ifdef MEM_IO_BRIDGE_PARITY_EN
  localparam int FL = 176;
`else
  localparam int FL = 160;
`endif

  mem_io_bridge #(.CLK_DIV(16), .RAM_WORDS(64)) dut (
    .clk      (clk),
    .reset    (reset),
    .memwrite (memwrite),
    .addr     (addr),
    .writedata(writedata),
    .readdata (readdata),
    .txd      (txd)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line level at position p (0-based cycle) within a frame of byte b
  function automatic logic exp_txd(input logic [7:0] b, input int p);
    int slot;
    slot = p / 16;
    if (slot == 0) return 1'b0;
    else if (slot <= 8) return b[slot-1];
`ifdef MEM_IO_BRIDGE_PARITY_EN
    else if (slot == 9) return ^b;
`endif
    else return 1'b1;
  endfunction

  task automatic test_reset();
    addr = STA;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b want 1", txd); end
    checks++;
    if (readdata !== 32'h0000_0002) begin errors++; $display("FAIL reset_status: got %h want 00000002", readdata); end
    tick();
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (readdata !== 32'h0000_0002) begin errors++; $display("FAIL post_reset_status: got %h want 00000002", readdata); end
  endtask

  task automatic test_ram();
    addr = 32'h0000_0000; writedata = 32'h1111_1111; memwrite = 1'b1; tick();
    addr = 32'h0000_0100; writedata = 32'h2222_2222; tick();
    addr = 32'h0000_1000; writedata = 32'h3333_3333; tick();
    addr = 32'h0000_00FC; writedata = 32'hCAFE_F00D; tick();
    addr = 32'h0000_0010; writedata = 32'hDEAD_BEEF; tick();
    memwrite = 1'b0;
    checks++;
    if (readdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_10: got %h want deadbeef", readdata); end
    addr = 32'h0000_0013; #1;
    checks++;
    if (readdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_13: got %h want deadbeef", readdata); end
    addr = 32'h0000_1000; #1;
    checks++;
    if (readdata !== 32'h0000_0000) begin errors++; $display("FAIL unmapped_1000: got %h want 00000000", readdata); end
    addr = 32'h0000_0000; #1;
    checks++;
    if (readdata !== 32'h1111_1111) begin errors++; $display("FAIL ram_0_no_alias: got %h want 11111111", readdata); end
    addr = 32'h0000_00FC; #1;
    checks++;
    if (readdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL ram_last: got %h want cafef00d", readdata); end
    addr = TXA; #1;
    checks++;
    if (readdata !== 32'h0000_0000) begin errors++; $display("FAIL txdata_read: got %h want 00000000", readdata); end
    addr = STA; #1;
    checks++;
    if (readdata !== 32'h0000_0002) begin errors++; $display("FAIL status_idle: got %h want 00000002", readdata); end
  endtask

  task automatic test_tx_single(input logic [7:0] b);
    int bad;
    int first_k;
    bad = 0;
    first_k = 0;
    addr = TXA; writedata = {24'h0, b}; memwrite = 1'b1;
    tick();
    memwrite = 1'b0; addr = STA;
    checks++;
    if (txd !== 1'b1) begin errors++; $display("FAIL tx_push_edge: got %b want 1", txd); end
    for (int k = 1; k <= FL; k++) begin
      tick();
      if (txd !== exp_txd(b, k - 1)) begin
        if (bad == 0) first_k = k;
        bad++;
      end
      if (k == 1) begin
        checks++;
        if (txd !== 1'b0) begin errors++; $display("FAIL tx_start_latency: got %b want 0", txd); end
      end
      if (k == FL) begin
        checks++;
        if (readdata !== 32'h0000_0006) begin errors++; $display("FAIL tx_active_last: got %h want 00000006", readdata); end
      end
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL tx_frame_%h: %0d wrong bits, first at cycle %0d, want 0", b, bad, first_k); end
    tick();
    checks++;
    if (readdata !== 32'h0000_0002) begin errors++; $display("FAIL tx_idle_after: got %h want 00000002", readdata); end
    checks++;
    if (txd !== 1'b1) begin errors++; $display("FAIL tx_idle_txd: got %b want 1", txd); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [6];
    int bad;
    int first_k;
    logic e;
    bytes = '{8'hA1, 8'h3C, 8'h0F, 8'hF0, 8'h96, 8'h5A};
    bad = 0;
    first_k = 0;
    for (int k = 0; k <= 5 * FL + 20; k++) begin
      if (k < 6) begin
        addr = TXA; writedata = {24'h0, bytes[k]}; memwrite = 1'b1;
      end else begin
        addr = STA; memwrite = 1'b0;
      end
      tick();
      if (k >= 1) begin
        if (k <= 5 * FL) e = exp_txd(bytes[(k - 1) / FL], (k - 1) % FL);
        else e = 1'b1;
        if (txd !== e) begin
          if (bad == 0) first_k = k;
          bad++;
        end
      end
      if (k == 6) begin
        checks++;
        if (readdata !== 32'h0000_000D) begin errors++; $display("FAIL b2b_full_overflow: got %h want 0000000d", readdata); end
      end
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL b2b_frames: %0d wrong bits, first at cycle %0d, want 0", bad, first_k); end
    checks++;
    if (readdata !== 32'h0000_000A) begin errors++; $display("FAIL b2b_idle_overflow: got %h want 0000000a", readdata); end
    addr = STA; writedata = 32'h0; memwrite = 1'b1;
    tick();
    memwrite = 1'b0;
    checks++;
    if (readdata !== 32'h0000_0002) begin errors++; $display("FAIL overflow_clear: got %h want 00000002", readdata); end
  endtask

  task automatic test_reset_mid();
    int bad;
    bad = 0;
    addr = TXA; memwrite = 1'b1;
    writedata = 32'h0000_003C; tick();
    writedata = 32'h0000_00A5; tick();
    writedata = 32'h0000_000F; tick();
    memwrite = 1'b0; addr = STA;
    for (int k = 0; k < 40; k++) tick();
    checks++;
    if (readdata !== 32'h0000_0004) begin errors++; $display("FAIL mid_pre_status: got %h want 00000004", readdata); end
    #3 reset = 1'b1;
    #1;
    checks++;
    if (txd !== 1'b1) begin errors++; $display("FAIL mid_reset_txd: got %b want 1", txd); end
    checks++;
    if (readdata !== 32'h0000_0002) begin errors++; $display("FAIL mid_reset_status: got %h want 00000002", readdata); end
    tick();
    reset = 1'b0;
    for (int k = 0; k < 400; k++) begin
      tick();
      if (txd !== 1'b1 || readdata !== 32'h0000_0002) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL mid_no_frames: %0d bad cycles, want 0", bad); end
    addr = 32'h0000_0010; #1;
    checks++;
    if (readdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_kept: got %h want deadbeef", readdata); end
    addr = STA;
  endtask

`ifdef MEM_IO_BRIDGE_PARITY_EN
  task automatic test_parity();
    addr = TXA; writedata = 32'h0000_0007; memwrite = 1'b1;
    tick();
    memwrite = 1'b0; addr = STA;
    for (int k = 1; k <= FL + 1; k++) begin
      tick();
      if (k == 137) begin
        checks++;
        if (txd !== 1'b0) begin errors++; $display("FAIL parity_bit7: got %b want 0", txd); end
      end
      if (k == 153) begin
        checks++;
        if (txd !== 1'b1) begin errors++; $display("FAIL parity_bit: got %b want 1", txd); end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_ram();
    test_tx_single(8'h55);
    test_tx_single(8'hC3);
    test_back_to_back();
    test_reset_mid();
`ifdef MEM_IO_BRIDGE_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
